note_player: RTL and testbench
==============================

Name: note_player

Overview:
- One instance per voice, directly downstream of the song reader. Consumes one voice's load_note/note/duration triple.
- Fetches the note's phase step from an external synchronous frequency ROM, then runs a phase accumulator that produces square-wave samples on each sample request.
- Counts the note's duration in beats and flags expiry.
- Three instances (voices 0-2) feed the mixer/codec stage.

Parameters:
- STEP_WIDTH, 20, width of the frequency step and of the phase accumulator.
- SAMPLE_WIDTH, 16, signed sample width.
- AMPLITUDE, 8192, square-wave magnitude (positive value, fits SAMPLE_WIDTH-1 bits).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- play  in  1  global run/pause level.
- fast_mode  in  1  when 1, duration counts down 2 per beat.
- beat  in  1  one-cycle beat strobe.
- load_note  in  1  one-cycle strobe: start a new note.
- note  in  6  note code; 0 = rest.
- duration  in  6  length in beats; 0 is treated as 1.
- generate_next_sample  in  1  one-cycle sample request from the codec.
- freq_rom_addr  out  6  registered note code presented to the frequency ROM.
- freq_rom_data  in  STEP_WIDTH  ROM step; valid one cycle after the address, registered ROM.
- sample  out  SAMPLE_WIDTH  signed sample, registered.
- sample_ready  out  1  one-cycle pulse: sample updated.
- busy  out  1  high in every state except S_IDLE.
- note_done  out  1  one-cycle registered pulse when a note expires naturally.

Behaviour:
- Async reset: all registers clear. Outputs reset to: state S_IDLE, sample 0, sample_ready 0, note_done 0, busy 0, freq_rom_addr 0. Internal step, phase and remaining also clear to 0.
- States: S_IDLE, S_ADDR, S_ROM_WAIT, S_PLAY.
- Transitions:
  - load_note in any state → latch note into note_q (drives freq_rom_addr) and duration into remaining (0→1), go to S_ADDR.
  - load_note always wins over every other event in the same cycle.
  - S_ADDR → S_ROM_WAIT unconditionally.
  - S_ROM_WAIT → S_PLAY. On that edge: step_q = (note_q==0) ? 0 : freq_rom_data, and phase = 0.
  - Latency: load_note in cycle c → first accumulation possible in cycle c+3.
- Duration in S_PLAY:
  - dec = fast_mode ? 2 : 1.
  - On beat && play: if remaining <= dec → go to S_IDLE, note_done=1 next cycle; else remaining -= dec.
  - Beat while !play is ignored. Beats in S_ADDR/S_ROM_WAIT are ignored.
- Preemption: load_note while busy restarts with the new note. No note_done is issued for the preempted note.
- load_note coinciding with an expiring beat: the load wins and no note_done is issued.
- Samples: on generate_next_sample, sample_ready=1 in the next cycle, in every state.
  - S_PLAY && play: phase = phase + step_q (mod 2^STEP_WIDTH). sample = (step_q==0) ? 0 : (phase_new[MSB] ? −AMPLITUDE : +AMPLITUDE).
  - S_PLAY && !play: phase is frozen and sample holds its value.
  - Other states: sample = 0.
- Mid-note reset clears everything immediately; no note_done is produced.
- freq_rom_addr changes only on load_note.

Test Plan:
- Reset: assert reset mid-S_PLAY → sample=0, busy=0, note_done=0 within the same cycle (async), and held while reset is high.
- Load note=10, duration=3, ROM returns 0x01000 → busy rises next cycle; freq_rom_addr=10; step captured at c+3. Three beats → note_done pulses once in the cycle after the 3rd beat; busy=0.
- Sample generation: step=0x40000, 4 requests in S_PLAY → phase 0x40000, 0x80000, 0xC0000, 0x00000 → samples +8192, −8192, −8192, +8192; sample_ready pulses 4×.
- fast_mode=1, duration=5 → expires on the 3rd beat (5→3→1→done). duration=0 → expires on the 1st beat.
- Preempt: load note=20 during an active note with remaining=4 → no note_done; new step used from c+3; new duration counted from full.
- Pause/rest: play=0 in S_PLAY with beats and sample requests → remaining and phase unchanged, sample held. Note=0 → samples 0 but duration still counts down and note_done fires.

Source files
------------

// File: rtl/note_player_if.sv
// Per-voice bus: song-reader note triple, transport controls, frequency ROM
// port and sample output toward the mixer.
interface note_player_if #(
  parameter int STEP_WIDTH   = 20,
  parameter int SAMPLE_WIDTH = 16
);
  logic                           play;
  logic                           fast_mode;
  logic                           beat;
  logic                           load_note;
  logic [5:0]                     note;
  logic [5:0]                     duration;
  logic                           generate_next_sample;
  logic [5:0]                     freq_rom_addr;
  logic [STEP_WIDTH-1:0]          freq_rom_data;
  logic signed [SAMPLE_WIDTH-1:0] sample;
  logic                           sample_ready;
  logic                           busy;
  logic                           note_done;

  modport slave (
    input  play, fast_mode, beat, load_note, note, duration,
           generate_next_sample, freq_rom_data,
    output freq_rom_addr, sample, sample_ready, busy, note_done
  );

  modport master (
    output play, fast_mode, beat, load_note, note, duration,
           generate_next_sample, freq_rom_data,
    input  freq_rom_addr, sample, sample_ready, busy, note_done
  );
endinterface

// File: rtl/note_player.sv
// Single voice: fetches the phase step from the frequency ROM, produces square-wave
// samples from a phase accumulator and counts the note length in beats.
module note_player #(
  parameter int STEP_WIDTH   = 20,
  parameter int SAMPLE_WIDTH = 16,
  parameter int AMPLITUDE    = 8192
) (
  input  logic          clk,
  input  logic          reset,
  note_player_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_ROM_WAIT, S_PLAY} state_t;

  localparam logic signed [SAMPLE_WIDTH-1:0] POS = SAMPLE_WIDTH'(AMPLITUDE);
  localparam logic signed [SAMPLE_WIDTH-1:0] NEG = -POS;

  state_t                         state_q, state_d;
  logic [5:0]                     note_q, note_d;
  logic [5:0]                     remaining_q, remaining_d;
  logic [STEP_WIDTH-1:0]          step_q, step_d;
  logic [STEP_WIDTH-1:0]          phase_q, phase_d;
  logic signed [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                           sample_ready_q, sample_ready_d;
  logic                           note_done_q, note_done_d;
  logic [STEP_WIDTH-1:0]          phase_sum;
  logic [5:0]                     dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      note_q         <= '0;
      remaining_q    <= '0;
      step_q         <= '0;
      phase_q        <= '0;
      sample_q       <= '0;
      sample_ready_q <= 1'b0;
      note_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      note_q         <= note_d;
      remaining_q    <= remaining_d;
      step_q         <= step_d;
      phase_q        <= phase_d;
      sample_q       <= sample_d;
      sample_ready_q <= sample_ready_d;
      note_done_q    <= note_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    note_d         = note_q;
    remaining_d    = remaining_q;
    step_d         = step_q;
    phase_d        = phase_q;
    sample_d       = sample_q;
    sample_ready_d = bus.generate_next_sample;
    note_done_d    = 1'b0;
    dec            = bus.fast_mode ? 6'd2 : 6'd1;
    phase_sum      = phase_q + step_q;

    // Paused playback keeps phase and the last sample untouched.
    if (bus.generate_next_sample) begin
      if (state_q == S_PLAY) begin
        if (bus.play) begin
          phase_d  = phase_sum;
          sample_d = (step_q == '0) ? '0 : (phase_sum[STEP_WIDTH-1] ? NEG : POS);
        end
      end else begin
        sample_d = '0;
      end
    end

    case (state_q)
      S_ADDR:     state_d = S_ROM_WAIT;
      S_ROM_WAIT: begin
        state_d = S_PLAY;
        step_d  = (note_q == 6'd0) ? '0 : bus.freq_rom_data;
        phase_d = '0;
      end
      S_PLAY: begin
        if (bus.beat && bus.play) begin
          if (remaining_q <= dec) begin
            state_d     = S_IDLE;
            note_done_d = 1'b1;
          end else begin
            remaining_d = remaining_q - dec;
          end
        end
      end
      default: ;
    endcase

    // A new note overrides expiry and any in-flight fetch.
    if (bus.load_note) begin
      state_d     = S_ADDR;
      note_d      = bus.note;
      remaining_d = (bus.duration == 6'd0) ? 6'd1 : bus.duration;
      note_done_d = 1'b0;
    end
  end

  assign bus.freq_rom_addr = note_q;
  assign bus.sample        = sample_q;
  assign bus.sample_ready  = sample_ready_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.note_done     = note_done_q;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_note_player;
  localparam logic signed [15:0] A = 16'sd8192;

  logic clk;
  logic reset;
  logic [19:0] rom [64];

  int vectors;
  int miscompares;

  note_player_if #(.STEP_WIDTH(20), .SAMPLE_WIDTH(16)) bus ();

  note_player #(.STEP_WIDTH(20), .SAMPLE_WIDTH(16), .AMPLITUDE(8192)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.freq_rom_data <= rom[bus.freq_rom_addr];

  // Model: busy flag, cycles left before playback, note length left in beats.
  bit                m_busy;
  int                m_wait;
  logic [5:0]        m_note;
  int                m_rem;
  logic [19:0]       m_step;
  logic [19:0]       m_phase;
  logic signed [15:0] m_sample;
  bit                m_ready;
  bit                m_done;

  task automatic model_clear();
    m_busy = 0; m_wait = 0; m_note = 0; m_rem = 0;
    m_step = 0; m_phase = 0; m_sample = 0; m_ready = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit playing;
    int dec;
    logic [19:0] ph;
    if (reset) begin
      model_clear();
      return;
    end
    playing = m_busy && (m_wait == 0);
    dec = bus.fast_mode ? 2 : 1;
    m_ready = bus.generate_next_sample;
    m_done = 0;
    if (bus.generate_next_sample) begin
      if (playing && bus.play) begin
        ph = m_phase + m_step;
        m_phase = ph;
        m_sample = (m_step == 0) ? 16'sd0 : (ph[19] ? -A : A);
      end else if (!playing) begin
        m_sample = 0;
      end
    end
    if (!bus.load_note && m_busy && m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_step = (m_note == 0) ? 20'd0 : rom[m_note];
        m_phase = 0;
      end
    end
    if (!bus.load_note && playing && bus.beat && bus.play) begin
      if (m_rem <= dec) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        m_rem -= dec;
      end
    end
    if (bus.load_note) begin
      m_busy = 1;
      m_wait = 2;
      m_note = bus.note;
      m_rem = (bus.duration == 0) ? 1 : int'(bus.duration);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d);
    bus.load_note = 1; bus.note = n; bus.duration = d;
    tick();
    bus.load_note = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_reset();
    load(6'd10, 6'd8);
    tick(); tick();
    bus.generate_next_sample = 1; tick(); bus.generate_next_sample = 0;
    vectors++;
    if (bus.sample !== A) begin
      miscompares++;
      $display("FAIL reset_pre_sample: got %0d want %0d", bus.sample, A);
    end
    #2 reset = 1;
    #1;
    vectors++;
    if (bus.sample !== 16'sd0 || bus.busy !== 1'b0 || bus.note_done !== 1'b0 ||
        bus.freq_rom_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_async: sample=%0d busy=%0b done=%0b addr=%0d want 0/0/0/0",
               bus.sample, bus.busy, bus.note_done, bus.freq_rom_addr);
    end
    bus.generate_next_sample = 1; bus.beat = 1;
    tick(); tick();
    bus.generate_next_sample = 0; bus.beat = 0;
    vectors++;
    if (bus.sample !== 16'sd0 || bus.busy !== 1'b0 || bus.sample_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: sample=%0d busy=%0b rdy=%0b want 0/0/0",
               bus.sample, bus.busy, bus.sample_ready);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_basic_note();
    int dones;
    load(6'd10, 6'd3);
    vectors++;
    if (bus.busy !== 1'b1 || bus.freq_rom_addr !== 6'd10) begin
      miscompares++;
      $display("FAIL basic_load: busy=%0b addr=%0d want 1/10", bus.busy, bus.freq_rom_addr);
    end
    tick(); tick();
    bus.generate_next_sample = 1; tick(); bus.generate_next_sample = 0;
    vectors++;
    if (bus.sample !== A || bus.sample_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_step_c3: sample=%0d rdy=%0b want %0d/1", bus.sample, bus.sample_ready, A);
    end
    dones = 0;
    for (int b = 1; b <= 3; b++) begin
      bus.beat = 1; tick(); bus.beat = 0;
      if (bus.note_done === 1'b1) dones++;
      if (b == 3) begin
        vectors++;
        if (bus.note_done !== 1'b1 || bus.busy !== 1'b0 || dones != 1) begin
          miscompares++;
          $display("FAIL basic_expire: done=%0b busy=%0b pulses=%0d want 1/0/1",
                   bus.note_done, bus.busy, dones);
        end
      end
    end
    tick();
    vectors++;
    if (bus.note_done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_pulse: done=%0b want 0", bus.note_done);
    end
  endtask

  task automatic test_samples();
    logic signed [15:0] exp_s [4];
    exp_s[0] = A; exp_s[1] = -A; exp_s[2] = -A; exp_s[3] = A;
    load(6'd5, 6'd20);
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      bus.generate_next_sample = 1; tick(); bus.generate_next_sample = 0;
      vectors++;
      if (bus.sample !== exp_s[k] || bus.sample_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL samples_%0d: sample=%0d rdy=%0b want %0d/1",
                 k, bus.sample, bus.sample_ready, exp_s[k]);
      end
      tick();
      vectors++;
      if (bus.sample_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL samples_rdy_pulse_%0d: rdy=%0b want 0", k, bus.sample_ready);
      end
    end
  endtask

  task automatic count_beats(input string name, input int want);
    int got;
    got = 0;
    for (int b = 1; b <= 8 && got == 0; b++) begin
      bus.beat = 1; tick(); bus.beat = 0;
      if (bus.note_done === 1'b1) got = b;
      tick();
    end
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: expired on beat %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_fast_mode();
    bus.fast_mode = 1;
    load(6'd7, 6'd5);
    tick(); tick();
    count_beats("fast_dur5", 3);
    bus.fast_mode = 0;
    load(6'd7, 6'd0);
    tick(); tick();
    count_beats("dur0", 1);
  endtask

  task automatic test_preempt();
    int dones;
    dones = 0;
    load(6'd10, 6'd6);
    tick(); tick();
    for (int b = 0; b < 2; b++) begin
      bus.beat = 1; tick(); bus.beat = 0;
      if (bus.note_done === 1'b1) dones++;
    end
    bus.beat = 1;
    load(6'd20, 6'd3);
    bus.beat = 0;
    if (bus.note_done === 1'b1) dones++;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (bus.note_done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || bus.freq_rom_addr !== 6'd20 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL preempt_no_done: pulses=%0d addr=%0d busy=%0b want 0/20/1",
               dones, bus.freq_rom_addr, bus.busy);
    end
    bus.generate_next_sample = 1; tick(); bus.generate_next_sample = 0;
    vectors++;
    if (bus.sample !== -A) begin
      miscompares++;
      $display("FAIL preempt_new_step: sample=%0d want %0d", bus.sample, -A);
    end
    count_beats("preempt_full_dur", 3);
  endtask

  task automatic test_pause_rest();
    load(6'd5, 6'd2);
    tick(); tick();
    bus.generate_next_sample = 1; tick(); bus.generate_next_sample = 0;
    bus.play = 0;
    for (int k = 0; k < 3; k++) begin
      bus.beat = 1; bus.generate_next_sample = 1; tick();
      bus.beat = 0; bus.generate_next_sample = 0;
      vectors++;
      if (bus.sample !== A || bus.sample_ready !== 1'b1 || bus.busy !== 1'b1 ||
          bus.note_done !== 1'b0) begin
        miscompares++;
        $display("FAIL pause_hold_%0d: sample=%0d rdy=%0b busy=%0b done=%0b want %0d/1/1/0",
                 k, bus.sample, bus.sample_ready, bus.busy, bus.note_done, A);
      end
    end
    bus.play = 1;
    bus.generate_next_sample = 1; tick(); bus.generate_next_sample = 0;
    vectors++;
    if (bus.sample !== -A) begin
      miscompares++;
      $display("FAIL pause_phase_frozen: sample=%0d want %0d", bus.sample, -A);
    end
    count_beats("pause_rem_kept", 2);
    load(6'd0, 6'd2);
    tick(); tick();
    bus.generate_next_sample = 1; tick(); bus.generate_next_sample = 0;
    vectors++;
    if (bus.sample !== 16'sd0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rest_sample: sample=%0d busy=%0b want 0/1", bus.sample, bus.busy);
    end
    count_beats("rest_expire", 2);
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.load_note = ($urandom_range(0, 24) == 0);
      bus.note = 6'($urandom_range(0, 63));
      bus.duration = 6'($urandom_range(0, 6));
      bus.beat = ($urandom_range(0, 3) == 0);
      bus.generate_next_sample = ($urandom_range(0, 2) == 0);
      bus.play = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) bus.fast_mode = ~bus.fast_mode;
      tick();
      vectors++;
      if (bus.sample !== m_sample || bus.sample_ready !== m_ready || bus.busy !== m_busy ||
          bus.note_done !== m_done || bus.freq_rom_addr !== m_note) begin
        miscompares++;
        $display("FAIL random_c%0d: sample=%0d rdy=%0b busy=%0b done=%0b addr=%0d want %0d/%0b/%0b/%0b/%0d",
                 c, bus.sample, bus.sample_ready, bus.busy, bus.note_done, bus.freq_rom_addr,
                 m_sample, m_ready, m_busy, m_done, m_note);
      end
    end
    bus.load_note = 0; bus.beat = 0; bus.generate_next_sample = 0;
    bus.play = 1; bus.fast_mode = 0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 64; i++) rom[i] = 20'($urandom);
    rom[0]  = 20'h12345;
    rom[5]  = 20'h40000;
    rom[10] = 20'h01000;
    rom[20] = 20'h80000;
    bus.play = 1; bus.fast_mode = 0; bus.beat = 0; bus.load_note = 0;
    bus.note = 0; bus.duration = 0; bus.generate_next_sample = 0;
    model_clear();
    reset = 1;
    #12;
    apply_reset();
    vectors++;
    if (bus.sample !== 16'sd0 || bus.busy !== 1'b0 || bus.note_done !== 1'b0 ||
        bus.sample_ready !== 1'b0 || bus.freq_rom_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_values: sample=%0d busy=%0b done=%0b rdy=%0b addr=%0d want all 0",
               bus.sample, bus.busy, bus.note_done, bus.sample_ready, bus.freq_rom_addr);
    end
    test_reset();
    test_basic_note();
    test_samples();
    test_fast_mode();
    test_preempt();
    test_pause_rest();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
